// File: rtl/param_serializer.sv
// rtl/param_serializer.sv - N_CH-to-1 frame serializer, one DW-bit channel word per clock; optional parity slot via SERIALIZER_PARITY_EN
module param_serializer #(
    parameter int N_CH      = 2,
    parameter int DW        = 1,
    parameter int MSB_FIRST = 0,
    localparam int CW       = ($clog2(N_CH + 1) > 1) ? $clog2(N_CH + 1) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_CH*DW-1:0] in_data,
    output logic [DW-1:0]      out_data,
    output logic               out_valid,
    output logic               out_sof,
    output logic [CW-1:0]      out_ch
);

`ifdef SERIALIZER_PARITY_EN
    localparam int SLOTS = N_CH + 1;
`else
    localparam int SLOTS = N_CH;
`endif
    localparam logic [CW-1:0] LAST = CW'(SLOTS - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [CW-1:0]       slot_q, slot_d;
    logic [N_CH*DW-1:0]  frame_q, frame_d;
    logic [DW-1:0]       out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_sof_q, out_sof_d;
    logic [CW-1:0]       out_ch_q, out_ch_d;
    logic                accept;

    // Ready depends on state only: idle, or about to emit the final slot of a frame
    always_comb begin
        in_ready = (state_q == S_IDLE) || ((state_q == S_SHIFT) && (slot_q == LAST));
        accept   = in_valid && in_ready;
    end

    // Next state / slot / frame; a frame reload at LAST keeps streaming with no bubble
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        frame_d = frame_q;
        if (accept) begin
            state_d = S_SHIFT;
            slot_d  = '0;
            frame_d = in_data;
        end else if (state_q == S_SHIFT) begin
            if (slot_q == LAST) begin
                state_d = S_IDLE;
                slot_d  = '0;
            end else begin
                slot_d = slot_q + CW'(1);
            end
        end
    end

    // Output values for the slot that becomes visible after this edge
    always_comb begin
        out_valid_d = (state_d == S_SHIFT);
        out_sof_d   = out_valid_d && (slot_d == '0);
        out_ch_d    = '0;
        out_data_d  = '0;
        if (out_valid_d) begin
            out_ch_d = (MSB_FIRST != 0) ? (CW'(N_CH - 1) - slot_d) : slot_d;
`ifdef SERIALIZER_PARITY_EN
            if (slot_d == CW'(N_CH)) begin
                out_ch_d = CW'(N_CH);
                for (int c = 0; c < N_CH; c++) begin
                    out_data_d = out_data_d ^ frame_d[c*DW +: DW];
                end
            end
`endif
            for (int c = 0; c < N_CH; c++) begin
                if (out_ch_d == CW'(c)) begin
                    out_data_d = frame_d[c*DW +: DW];
                end
            end
        end
    end

    // State and registered outputs; reset discards any frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            slot_q      <= '0;
            frame_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            frame_q     <= frame_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_ch    = out_ch_q;

endmodule

// File: doc/param_serializer.md
Name: param_serializer

Overview:
Parametrised N-to-1 serializer, successor to the fixed 2-channel, 1-bit serializer. Captures one frame of N_CH parallel channel words per handshake and emits them one channel per clock on a DW-bit serial lane. Runs on a single clock: no divided clock and no second clock domain. A frame marker and a channel index accompany every output slot.

Parameters:
N_CH, 2, number of input channels (>=2); channel 0 occupies in_data[DW-1:0].
DW, 1, bits per channel and width of the serial lane (>=1).
MSB_FIRST, 0, 0: channel 0 is sent first; 1: channel N_CH-1 is sent first.

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_data holds a valid frame
in_ready  output  1  block accepts a frame this cycle
in_data  input  N_CH*DW  parallel frame, channel c at [c*DW +: DW]
out_data  output  DW  current serial slot
out_valid  output  1  out_data is valid
out_sof  output  1  high on the first slot of each frame
out_ch  output  max(1,clog2(N_CH+1))  channel index of current slot (parity slot = N_CH)

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_sof=0, out_data=0, out_ch=0, shift register cleared.
- Reset asserted mid-frame discards the frame; the outputs above are reached on the next edge.
- Handshake: a frame is accepted on any edge where in_valid && in_ready. in_data is sampled only on accept.
- in_ready = (state==IDLE) || (state==SHIFT && slot==LAST). LAST is N_CH-1, or N_CH with the parity option.
- in_ready is combinational from state only, never from in_valid.
- The output side has no backpressure: one slot is emitted per cycle while in SHIFT.
- States:
  - IDLE: on accept, load the shift register, slot=0, go to SHIFT.
  - SHIFT: each cycle, slot increments.
  - At slot==LAST with accept: reload, slot=0, stay in SHIFT. Back-to-back frames have no bubble.
  - At slot==LAST without accept: go to IDLE.
- Latency: a frame accepted at edge k has its first slot visible after edge k (cycle k+1). The last data slot appears in cycle k+N_CH.
- Outputs are registered, with these values per slot:
  - out_valid=1 throughout SHIFT.
  - out_sof=1 only when slot==0.
  - out_ch = slot when MSB_FIRST=0, N_CH-1-slot when MSB_FIRST=1. The parity slot always reports N_CH.
  - out_data is the channel word for out_ch.
- In IDLE, out_valid=0 and out_data=0 (forced zero, not held).
- Throughput: one frame per N_CH cycles (N_CH+1 with parity).
- Slot counter is width clog2(N_CH+1) and never wraps past LAST. Non-power-of-2 N_CH must work (e.g. N_CH=3).
- Compatibility: N_CH=2, DW=1, MSB_FIRST=0 gives the legacy ordering: data1 as channel 0, then data2.

Optional Feature:
Macro SERIALIZER_PARITY_EN.
- Defined: each frame gets one extra slot after the N_CH data slots. out_data on that slot is the bitwise XOR of all N_CH channel words, with out_ch=N_CH and out_valid=1. LAST=N_CH, and in_ready asserts during the parity slot.
- Not defined: no parity slot, LAST=N_CH-1, no parity logic synthesised. out_ch never reaches N_CH.

Test Plan:
1. N_CH=4, DW=8, MSB_FIRST=0: hold reset 3 cycles -> out_valid=0, out_data=0, in_ready=1. Single frame in_data=0x44332211 -> out_data 0x11,0x22,0x33,0x44 in cycles k+1..k+4; out_sof only on 0x11; out_ch 0,1,2,3; then out_valid=0.
2. Same config, in_valid held high with frames 0x44332211 then 0x88776655 -> 8 consecutive valid slots 0x11..0x44,0x55..0x88, no gap; in_ready high on slot 3 only after the first accept.
3. MSB_FIRST=1, frame 0x44332211 -> out_data 0x44,0x33,0x22,0x11; out_ch 3,2,1,0; out_sof on 0x44.
4. N_CH=3, DW=1, frames 3'b101 then 3'b011 back-to-back -> out_data 1,0,1,1,1,0; counter never exceeds 2; in_ready high on every 3rd slot.
5. N_CH=4, DW=8, reset pulsed on slot 2 of frame 0x44332211 -> next cycle out_valid=0, out_data=0, in_ready=1. A new frame 0xDDCCBBAA then emits 0xAA first with out_sof=1.
6. SERIALIZER_PARITY_EN defined, N_CH=4, DW=8, frame 0x44332211 -> slots 0x11,0x22,0x33,0x44,0x44 (parity) with out_ch=4; in_ready high only on the parity slot; back-to-back period 5 cycles.
